// File: rtl/bin_threshold_filter.sv
`timescale 1ns/1ps
// Grayscale binarization with a per-frame latched threshold, followed by a
// 3-tap horizontal majority filter; two register stages, one pixel out per pixel in.
module bin_threshold_filter #(
    parameter int unsigned H_ACT = 640,
    parameter int unsigned V_ACT = 480
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iDVAL,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    input  logic [9:0] iTHRESH,
    input  logic       iBYPASS,
    output logic [9:0] oDATA,
    output logic       oDVAL
);

    localparam int unsigned DW = 10;
    localparam int unsigned SW = 12;
    localparam int unsigned XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [DW-1:0] thr_q, thr_d;
    logic          s1_b_q, s1_b_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s1_first_q, s1_first_d;
    logic          h1_q, h1_d;
    logic          h2_q, h2_d;
    logic          hv1_q, hv1_d;
    logic          hv2_q, hv2_d;
    logic [DW-1:0] data_q, data_d;
    logic          dval_q, dval_d;

    logic [SW-1:0] gray_sum;
    logic          frame_start;
    logic [DW-1:0] thr_use;
    logic          n1, n2, maj;

    assign gray_sum    = SW'(iRed) + SW'({iGreen, 1'b0}) + SW'(iBlue);
    assign frame_start = (x_q == '0) && (y_q == '0);
    assign thr_use     = frame_start ? iTHRESH : thr_q;

    // Missing left neighbours (line start) fall back to the current pixel.
    assign n1  = (hv1_q && !s1_first_q) ? h1_q : s1_b_q;
    assign n2  = (hv2_q && !s1_first_q) ? h2_q : s1_b_q;
    assign maj = (s1_b_q & n1) | (s1_b_q & n2) | (n1 & n2);

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        thr_d      = thr_q;
        s1_b_d     = s1_b_q;
        s1_vld_d   = iDVAL;
        s1_first_d = s1_first_q;
        h1_d       = h1_q;
        h2_d       = h2_q;
        hv1_d      = hv1_q;
        hv2_d      = hv2_q;
        data_d     = data_q;
        dval_d     = s1_vld_q;

        if (iDVAL) begin
            // floor(sum/4) < thr is the same as sum < 4*thr, so no bits are dropped
            s1_b_d     = (gray_sum >= {thr_use, 2'b00});
            s1_first_d = (x_q == '0);
            if (frame_start) begin
                thr_d = iTHRESH;
            end
            if (x_q == XW'(H_ACT - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(V_ACT - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        if (s1_vld_q) begin
            data_d = (iBYPASS ? s1_b_q : maj) ? {DW{1'b1}} : '0;
            h1_d   = s1_b_q;
            h2_d   = h1_q;
            hv1_d  = 1'b1;
            hv2_d  = hv1_q && !s1_first_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_q        <= '0;
            y_q        <= '0;
            thr_q      <= '0;
            s1_b_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            h1_q       <= 1'b0;
            h2_q       <= 1'b0;
            hv1_q      <= 1'b0;
            hv2_q      <= 1'b0;
            data_q     <= '0;
            dval_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            thr_q      <= thr_d;
            s1_b_q     <= s1_b_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            h1_q       <= h1_d;
            h2_q       <= h2_d;
            hv1_q      <= hv1_d;
            hv2_q      <= hv2_d;
            data_q     <= data_d;
            dval_q     <= dval_d;
        end
    end

    assign oDATA = data_q;
    assign oDVAL = dval_q;

endmodule

// File: tb/tb_bin_threshold_filter.sv
`timescale 1ns/1ps
// Bench for bin_threshold_filter on a reduced raster, against a line-buffer
// reference model of gray/threshold/majority behaviour.
module tb_bin_threshold_filter;

    localparam int H = 320;
    localparam int V = 12;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iDVAL;
    logic [9:0] iRed, iGreen, iBlue, iTHRESH;
    logic       iBYPASS;
    logic [9:0] oDATA;
    logic       oDVAL;

    bin_threshold_filter #(.H_ACT(H), .V_ACT(V)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iTHRESH(iTHRESH), .iBYPASS(iBYPASS),
        .oDATA(oDATA), .oDVAL(oDVAL)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic v;
        logic raw;
        logic maj;
        int   x;
        int   y;
    } ent_t;

    int         mx, my;
    logic [9:0] mthr;
    logic       lb[H];
    ent_t       pipe[$];
    logic [9:0] last_d;
    int         n_checks, n_pass;

    task automatic model_reset();
        mx = 0;
        my = 0;
        mthr = 10'd0;
        pipe.delete();
        pipe.push_back('{v: 1'b0, raw: 1'b0, maj: 1'b0, x: 0, y: 0});
        last_d = 10'd0;
    endtask

    task automatic do_reset();
        iRST = 1'b0;
        iDVAL = 1'b0;
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        model_reset();
    endtask

    // Drive one cycle, advance the model, return what the outputs should show now.
    task automatic cycle(input logic dv, input logic [9:0] r, input logic [9:0] gg,
                         input logic [9:0] b, input logic [9:0] th, input logic byp,
                         output ent_t e, output logic [9:0] ed);
        ent_t n;
        int   g10;
        logic pb, p1, p2;
        n = '{v: 1'b0, raw: 1'b0, maj: 1'b0, x: mx, y: my};
        iDVAL = dv; iRed = r; iGreen = gg; iBlue = b; iTHRESH = th; iBYPASS = byp;
        if (dv) begin
            if (mx == 0 && my == 0) mthr = th;
            g10 = (int'(r) + 2 * int'(gg) + int'(b)) / 4;
            pb = (g10 >= int'(mthr));
            lb[mx] = pb;
            p1 = (mx >= 1) ? lb[mx-1] : pb;
            p2 = (mx >= 2) ? lb[mx-2] : pb;
            n.v = 1'b1;
            n.raw = pb;
            n.maj = ((int'(pb) + int'(p1) + int'(p2)) >= 2);
            mx++;
            if (mx == H) begin
                mx = 0;
                my++;
                if (my == V) my = 0;
            end
        end
        pipe.push_back(n);
        @(posedge iCLK);
        #1;
        e = pipe.pop_front();
        if (e.v) last_d = (byp ? e.raw : e.maj) ? 10'd1023 : 10'd0;
        ed = last_d;
    endtask

    task automatic test_reset();
        iRST = 1'b0; iDVAL = 1'b0; iRed = '0; iGreen = '0; iBlue = '0;
        iTHRESH = '0; iBYPASS = 1'b0;
        @(posedge iCLK);
        #1;
        n_checks++;
        if (oDVAL !== 1'b0) $display("FAIL reset_dval: got %b want 0", oDVAL);
        else n_pass++;
        n_checks++;
        if (oDATA !== 10'd0) $display("FAIL reset_data: got %0d want 0", oDATA);
        else n_pass++;
        iRST = 1'b1;
        model_reset();
    endtask

    task automatic test_gray_threshold();
        int unsigned tr[4] = '{400, 400, 1023, 1023};
        int unsigned tg[4] = '{400, 400, 0, 0};
        int unsigned tb[4] = '{400, 400, 0, 0};
        int unsigned tt[4] = '{401, 400, 256, 255};
        int unsigned tx[4] = '{0, 1023, 0, 1023};
        ent_t e;
        logic [9:0] ed;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            for (int k = 0; k < 3; k++) begin
                cycle(k == 0, 10'(tr[i]), 10'(tg[i]), 10'(tb[i]), 10'(tt[i]), 1'b0, e, ed);
                n_checks++;
                if (oDVAL !== e.v || oDATA !== ed)
                    $display("FAIL gray_stream case=%0d k=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                             i, k, oDVAL, oDATA, e.v, ed);
                else n_pass++;
                if (k == 1) begin
                    n_checks++;
                    if (oDVAL !== 1'b1 || oDATA !== 10'(tx[i]))
                        $display("FAIL gray_latency case=%0d: got dval=%b data=%0d want dval=1 data=%0d",
                                 i, oDVAL, oDATA, tx[i]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_speckle();
        int ecnt[3]  = '{0, 2, 1};
        int efst[3]  = '{0, 301, 300};
        int elst[3]  = '{0, 302, 300};
        ent_t e;
        logic [9:0] ed, pv;
        int zc, zf, zl;
        for (int c = 0; c < 3; c++) begin
            do_reset();
            zc = 0; zf = -1; zl = -1;
            for (int k = 0; k < H + 2; k++) begin
                pv = (k == 300 || (c == 1 && k == 301)) ? 10'd0 : 10'd1023;
                cycle(k < H, pv, pv, pv, 10'd512, c == 2, e, ed);
                n_checks++;
                if (oDVAL !== e.v || oDATA !== ed)
                    $display("FAIL speckle_stream case=%0d x=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                             c, e.x, oDVAL, oDATA, e.v, ed);
                else n_pass++;
                if (oDVAL === 1'b1 && oDATA === 10'd0) begin
                    if (zc == 0) zf = e.x;
                    zl = e.x;
                    zc++;
                end
            end
            n_checks++;
            if (zc != ecnt[c] || (zc > 0 && (zf != efst[c] || zl != elst[c])))
                $display("FAIL speckle_zeros case=%0d: got count=%0d first=%0d last=%0d want count=%0d first=%0d last=%0d",
                         c, zc, zf, zl, ecnt[c], efst[c], elst[c]);
            else n_pass++;
        end
    endtask

    task automatic test_line_boundary();
        ent_t e;
        logic [9:0] ed, pv;
        for (int k = 0; k < 2 * H + 2; k++) begin
            if (k == 0) do_reset();
            pv = (k == H - 2 || k == H - 1) ? 10'd0 : 10'd1023;
            cycle(k < 2 * H, pv, pv, pv, 10'd512, 1'b0, e, ed);
            n_checks++;
            if (oDVAL !== e.v || oDATA !== ed)
                $display("FAIL boundary_stream x=%0d y=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                         e.x, e.y, oDVAL, oDATA, e.v, ed);
            else n_pass++;
            if (e.v && e.y == 1 && e.x < 2) begin
                n_checks++;
                if (oDATA !== 10'd1023)
                    $display("FAIL boundary_carry x=%0d: got %0d want 1023", e.x, oDATA);
                else n_pass++;
            end
        end
    endtask

    task automatic test_frame_thresh();
        ent_t e;
        logic [9:0] ed, th, r, g, b;
        logic dv, byp;
        int sent, pulses, bad;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            sent = 0; pulses = 0; bad = 0;
            while (sent < H * V) begin
                dv  = ($urandom_range(0, 3) != 0);
                th  = (f == 0 && my < 10) ? 10'd100 : 10'd900;
                byp = 1'($urandom_range(0, 1));
                if ((f == 0 && my >= 10) || (f == 1 && my < 2)) begin
                    r = 10'd500; g = 10'd500; b = 10'd500;
                end else begin
                    r = 10'($urandom_range(0, 1023));
                    g = 10'($urandom_range(0, 1023));
                    b = 10'($urandom_range(0, 1023));
                end
                cycle(dv, r, g, b, th, byp, e, ed);
                if (dv) sent++;
                n_checks++;
                if (oDVAL !== e.v || oDATA !== ed)
                    $display("FAIL frame_stream f=%0d x=%0d y=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                             f, e.x, e.y, oDVAL, oDATA, e.v, ed);
                else n_pass++;
                if (oDVAL === 1'b1) pulses++;
                if (e.v && f == 0 && e.y >= 10 && oDATA !== 10'd1023) bad++;
                if (e.v && f == 1 && e.y < 2 && oDATA !== 10'd0) bad++;
            end
            cycle(1'b0, 10'd0, 10'd0, 10'd0, 10'd900, 1'b0, e, ed);
            n_checks++;
            if (oDVAL !== e.v || oDATA !== ed)
                $display("FAIL frame_tail f=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                         f, oDVAL, oDATA, e.v, ed);
            else n_pass++;
            if (oDVAL === 1'b1) pulses++;
            n_checks++;
            if (pulses != H * V) $display("FAIL frame_pulses f=%0d: got %0d want %0d", f, pulses, H * V);
            else n_pass++;
            n_checks++;
            if (bad != 0) $display("FAIL frame_thresh_latch f=%0d: got %0d wrong pixels want 0", f, bad);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        ent_t e;
        logic [9:0] ed, r, g, b;
        logic dv;
        int sent, pulses, seen0;
        do_reset();
        while (!(my == V / 2 && mx >= 5)) begin
            dv = ($urandom_range(0, 3) != 0);
            cycle(dv, 10'd1023, 10'd1023, 10'd1023, 10'd512, 1'b0, e, ed);
            n_checks++;
            if (oDVAL !== e.v || oDATA !== ed)
                $display("FAIL midrst_pre x=%0d y=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                         e.x, e.y, oDVAL, oDATA, e.v, ed);
            else n_pass++;
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 10'd1023, 10'd1023, 10'd1023, 10'd512, 1'b0, e, ed);
            n_checks++;
            if (oDVAL !== 1'b1 || oDATA !== 10'd1023)
                $display("FAIL midrst_before k=%0d: got dval=%b data=%0d want dval=1 data=1023", k, oDVAL, oDATA);
            else n_pass++;
        end
        #2;
        iRST = 1'b0;
        #1;
        n_checks++;
        if (oDVAL !== 1'b0) $display("FAIL midrst_dval: got %b want 0", oDVAL);
        else n_pass++;
        n_checks++;
        if (oDATA !== 10'd0) $display("FAIL midrst_data: got %0d want 0", oDATA);
        else n_pass++;
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        model_reset();
        sent = 0; pulses = 0; seen0 = 0;
        while (sent < H * V) begin
            dv = (sent == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (sent == 0) begin
                r = 10'd700; g = 10'd700; b = 10'd700;
            end else begin
                r = 10'($urandom_range(0, 1023));
                g = 10'($urandom_range(0, 1023));
                b = 10'($urandom_range(0, 1023));
            end
            cycle(dv, r, g, b, (sent == 0) ? 10'd1000 : 10'd0, 1'b0, e, ed);
            if (dv) sent++;
            n_checks++;
            if (oDVAL !== e.v || oDATA !== ed)
                $display("FAIL midrst_stream x=%0d y=%0d: got dval=%b data=%0d want dval=%b data=%0d",
                         e.x, e.y, oDVAL, oDATA, e.v, ed);
            else n_pass++;
            if (oDVAL === 1'b1) pulses++;
            if (e.v && e.x == 0 && e.y == 0 && seen0 == 0) begin
                seen0 = 1;
                n_checks++;
                if (oDATA !== 10'd0) $display("FAIL midrst_relatch: got %0d want 0", oDATA);
                else n_pass++;
            end
        end
        cycle(1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, e, ed);
        if (oDVAL === 1'b1) pulses++;
        n_checks++;
        if (pulses != H * V) $display("FAIL midrst_pulses: got %0d want %0d", pulses, H * V);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        model_reset();
        test_reset();
        test_gray_threshold();
        test_speckle();
        test_line_boundary();
        test_frame_thresh();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
